// File: rtl/usb_stream_buffer_if.sv
// ---------------------------------------------------------------------------
// usb_stream_buffer_if : byte-stream handshakes between CPU FIFO and USB_CDC
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface usb_stream_buffer_if #(
  parameter int TX_DEPTH = 64,
  parameter int RX_DEPTH = 16
);
  logic [7:0]                  cpu_in_data_i;
  logic                        cpu_in_valid_i;
  logic                        cpu_in_ready_o;
  logic [7:0]                  usb_in_data_o;
  logic                        usb_in_valid_o;
  logic                        usb_in_ready_i;
  logic [7:0]                  usb_out_data_i;
  logic                        usb_out_valid_i;
  logic                        usb_out_ready_o;
  logic [7:0]                  cpu_out_data_o;
  logic                        cpu_out_valid_o;
  logic                        cpu_out_ready_i;
  logic [$clog2(TX_DEPTH):0]   tx_level_o;
  logic [$clog2(RX_DEPTH):0]   rx_level_o;

  modport slave (
    input  cpu_in_data_i, cpu_in_valid_i, usb_in_ready_i,
    input  usb_out_data_i, usb_out_valid_i, cpu_out_ready_i,
    output cpu_in_ready_o, usb_in_data_o, usb_in_valid_o,
    output usb_out_ready_o, cpu_out_data_o, cpu_out_valid_o,
    output tx_level_o, rx_level_o
  );

  modport master (
    output cpu_in_data_i, cpu_in_valid_i, usb_in_ready_i,
    output usb_out_data_i, usb_out_valid_i, cpu_out_ready_i,
    input  cpu_in_ready_o, usb_in_data_o, usb_in_valid_o,
    input  usb_out_ready_o, cpu_out_data_o, cpu_out_valid_o,
    input  tx_level_o, rx_level_o
  );
endinterface

`default_nettype wire

// File: rtl/usb_stream_buffer.sv
// ---------------------------------------------------------------------------
// usb_stream_buffer : bursty TX FIFO (newline / level / idle flush) and plain
//                     RX FIFO between the CPU byte streams and USB_CDC.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_stream_buffer #(
  parameter int TX_DEPTH    = 64,
  parameter int RX_DEPTH    = 16,
  parameter int FLUSH_LEVEL = 32,
  parameter int TIMEOUT     = 48000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  usb_stream_buffer_if.slave bus
);

  localparam int c_tx_aw  = $clog2(TX_DEPTH);
  localparam int c_tx_lw  = c_tx_aw + 1;
  localparam int c_rx_aw  = $clog2(RX_DEPTH);
  localparam int c_rx_lw  = c_rx_aw + 1;
  localparam int c_idle_w = $clog2(TIMEOUT + 1);

  localparam logic [c_tx_lw-1:0]  c_tx_full  = c_tx_lw'(TX_DEPTH);
  localparam logic [c_tx_lw-1:0]  c_flush    = c_tx_lw'(FLUSH_LEVEL);
  localparam logic [c_rx_lw-1:0]  c_rx_full  = c_rx_lw'(RX_DEPTH);
  localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_HOLD  = 1'b0,
    S_DRAIN = 1'b1
  } tx_state_t;

  // ---------------- TX path ----------------
  logic [7:0]          r_tx_mem [TX_DEPTH];
  logic [c_tx_aw-1:0]  r_tx_wr;
  logic [c_tx_aw-1:0]  r_tx_rd;
  logic [c_tx_lw-1:0]  r_tx_level;
  logic [c_tx_lw-1:0]  w_tx_level_next;
  tx_state_t           r_state;
  tx_state_t           w_state_next;
  logic                r_nl_pending;
  logic                w_nl_next;
  logic [c_idle_w-1:0] r_idle;
  logic [c_idle_w-1:0] w_idle_next;
  logic                w_tx_ready;
  logic                w_tx_push;
  logic                w_tx_valid;
  logic                w_tx_pop;
  logic                w_tx_nonempty;
  logic                w_is_nl;

  // Outputs are qualified with rst_i so nothing is offered while reset is held.
  assign w_tx_nonempty = !rst_i && (r_tx_level != '0);
  assign w_tx_ready    = !rst_i && (r_tx_level != c_tx_full);
  assign w_tx_push     = bus.cpu_in_valid_i && w_tx_ready;
  assign w_tx_valid    = w_tx_nonempty && (r_state == S_DRAIN);
  assign w_tx_pop      = w_tx_valid && bus.usb_in_ready_i;
  assign w_is_nl       = w_tx_push && (bus.cpu_in_data_i == 8'h0A);

  always_comb begin
    w_tx_level_next = r_tx_level + c_tx_lw'(w_tx_push) - c_tx_lw'(w_tx_pop);
  end

  always_comb begin
    w_state_next = r_state;
    w_nl_next    = r_nl_pending | w_is_nl;
    w_idle_next  = '0;
    case (r_state)
      S_HOLD: begin
        if (w_nl_next || (w_tx_level_next >= c_flush) ||
            ((r_idle == c_idle_max) && (r_tx_level != '0))) begin
          w_state_next = S_DRAIN;
        end else if (!w_tx_push && (r_tx_level != '0)) begin
          w_idle_next = (r_idle == c_idle_max) ? r_idle : r_idle + c_idle_w'(1);
        end
      end
      S_DRAIN: begin
        // Stay while anything is queued or still arriving, so late bytes join the burst.
        if ((r_tx_level == '0) && !w_tx_push) begin
          w_state_next = S_HOLD;
          w_nl_next    = 1'b0;
        end
      end
      default: w_state_next = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_HOLD;
      r_nl_pending <= 1'b0;
      r_idle       <= '0;
      r_tx_wr      <= '0;
      r_tx_rd      <= '0;
      r_tx_level   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_nl_pending <= w_nl_next;
      r_idle       <= w_idle_next;
      r_tx_level   <= w_tx_level_next;
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_tx_aw'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_tx_aw'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.cpu_in_data_i;
  end

  assign bus.cpu_in_ready_o = w_tx_ready;
  assign bus.usb_in_valid_o = w_tx_valid;
  assign bus.usb_in_data_o  = w_tx_nonempty ? r_tx_mem[r_tx_rd] : 8'h00;
  assign bus.tx_level_o     = rst_i ? '0 : r_tx_level;

  // ---------------- RX path ----------------
  logic [7:0]          r_rx_mem [RX_DEPTH];
  logic [c_rx_aw-1:0]  r_rx_wr;
  logic [c_rx_aw-1:0]  r_rx_rd;
  logic [c_rx_lw-1:0]  r_rx_level;
  logic                w_rx_ready;
  logic                w_rx_push;
  logic                w_rx_valid;
  logic                w_rx_pop;

  // Ready comes from the registered level: a full FIFO refuses a push even if it pops.
  assign w_rx_ready = !rst_i && (r_rx_level != c_rx_full);
  assign w_rx_push  = bus.usb_out_valid_i && w_rx_ready;
  assign w_rx_valid = !rst_i && (r_rx_level != '0);
  assign w_rx_pop   = w_rx_valid && bus.cpu_out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_level <= '0;
    end else begin
      r_rx_level <= r_rx_level + c_rx_lw'(w_rx_push) - c_rx_lw'(w_rx_pop);
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_rx_aw'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_rx_aw'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= bus.usb_out_data_i;
  end

  assign bus.usb_out_ready_o = w_rx_ready;
  assign bus.cpu_out_valid_o = w_rx_valid;
  assign bus.cpu_out_data_o  = w_rx_valid ? r_rx_mem[r_rx_rd] : 8'h00;
  assign bus.rx_level_o      = rst_i ? '0 : r_rx_level;

endmodule

`default_nettype wire
